// File: rtl/round_check_ctrl_if.sv
// Handshake bundle between the game FSM / button synchronisers and round_check_ctrl.
// The master side drives the round request and pattern; the slave side reports progress and result.
interface round_check_ctrl_if #(
    parameter int MAX_LEN = 33
);
    logic                    start;
    logic [5:0]              round_len;
    logic [MAX_LEN-1:0][1:0] segment;
    logic [3:0]              player_input;
    logic                    busy;
    logic [5:0]              check_idx;
    logic                    round_pass;
    logic                    round_fail;
    logic [1:0]              fail_code;

    modport master (
        output start, round_len, segment, player_input,
        input  busy, check_idx, round_pass, round_fail, fail_code
    );

    modport slave (
        input  start, round_len, segment, player_input,
        output busy, check_idx, round_pass, round_fail, fail_code
    );
endinterface

// File: rtl/round_check_ctrl.sv
// Simon Says response-round sequencer: walks check_idx through the first round_len
// pattern entries, one press/release per entry, and ends with a registered pass/fail pulse.
module round_check_ctrl #(
    parameter int MAX_LEN        = 33,
    parameter int TIMEOUT_CYCLES = 500_000_000
) (
    input logic              clk,
    input logic              reset,
    round_check_ctrl_if.slave bus
);

    localparam int                CNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [6:0]        LEN_MAX  = 7'(MAX_LEN);

    localparam logic [1:0] CODE_WRONG   = 2'd0;
    localparam logic [1:0] CODE_TIMEOUT = 2'd1;
    localparam logic [1:0] CODE_MULTI   = 2'd2;
    localparam logic [1:0] CODE_BADLEN  = 2'd3;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        WAIT_PRESS   = 2'd1,
        WAIT_RELEASE = 2'd2,
        FINISH       = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [5:0]       idx_q, idx_d;
    logic [5:0]       len_q, len_d;
    logic             busy_q, busy_d;
    logic             pass_q, pass_d;
    logic             fail_q, fail_d;
    logic [1:0]       code_q, code_d;
    logic             pulsed_q, pulsed_d;
    logic             res_pass_q, res_pass_d;

    logic             multi_btn;
    logic             any_btn;
    logic [1:0]       pressed_colour;
    logic [1:0]       want_colour;
    logic             len_illegal;

    // Counter saturates at the timeout value so it can never wrap.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_LAST) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [1:0] btn_colour(input logic [3:0] v);
        logic [1:0] c;
        if (v[3])      c = 2'd3;
        else if (v[2]) c = 2'd2;
        else if (v[1]) c = 2'd1;
        else           c = 2'd0;
        return c;
    endfunction

    assign multi_btn      = |(bus.player_input & (bus.player_input - 4'd1));
    assign any_btn        = |bus.player_input;
    assign pressed_colour = btn_colour(bus.player_input);
    assign want_colour    = bus.segment[idx_q];
    assign len_illegal    = (bus.round_len == 6'd0) || ({1'b0, bus.round_len} > LEN_MAX);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        len_d      = len_q;
        pass_d     = 1'b0;
        fail_d     = 1'b0;
        code_d     = code_q;
        pulsed_d   = pulsed_q;
        res_pass_d = res_pass_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    idx_d    = 6'd0;
                    cnt_d    = '0;
                    code_d   = CODE_WRONG;
                    pulsed_d = 1'b0;
                    if (len_illegal) begin
                        code_d     = CODE_BADLEN;
                        res_pass_d = 1'b0;
                        state_d    = FINISH;
                    end else begin
                        len_d   = bus.round_len;
                        state_d = WAIT_PRESS;
                    end
                end
            end

            WAIT_PRESS: begin
                cnt_d = sat_inc(cnt_q);
                if (multi_btn) begin
                    code_d     = CODE_MULTI;
                    res_pass_d = 1'b0;
                    pulsed_d   = 1'b0;
                    state_d    = FINISH;
                end else if (any_btn) begin
                    if (pressed_colour == want_colour) begin
                        state_d = WAIT_RELEASE;
                    end else begin
                        code_d     = CODE_WRONG;
                        res_pass_d = 1'b0;
                        pulsed_d   = 1'b0;
                        state_d    = FINISH;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    code_d     = CODE_TIMEOUT;
                    res_pass_d = 1'b0;
                    pulsed_d   = 1'b0;
                    state_d    = FINISH;
                end
            end

            // Extra buttons while the correct one is held are deliberately ignored here.
            WAIT_RELEASE: begin
                if (!any_btn) begin
                    if (idx_q == len_q - 6'd1) begin
                        res_pass_d = 1'b1;
                        pulsed_d   = 1'b0;
                        state_d    = FINISH;
                    end else begin
                        idx_d   = idx_q + 6'd1;
                        cnt_d   = '0;
                        state_d = WAIT_PRESS;
                    end
                end
            end

            // Two cycles here: the first raises the pulse, the second returns to IDLE,
            // so busy stays high while the pulse is visible.
            FINISH: begin
                if (!pulsed_q) begin
                    pass_d   = res_pass_q;
                    fail_d   = !res_pass_q;
                    pulsed_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= 6'd0;
            len_q      <= 6'd0;
            busy_q     <= 1'b0;
            pass_q     <= 1'b0;
            fail_q     <= 1'b0;
            code_q     <= 2'd0;
            pulsed_q   <= 1'b0;
            res_pass_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            len_q      <= len_d;
            busy_q     <= busy_d;
            pass_q     <= pass_d;
            fail_q     <= fail_d;
            code_q     <= code_d;
            pulsed_q   <= pulsed_d;
            res_pass_q <= res_pass_d;
        end
    end

    assign bus.busy       = busy_q;
    assign bus.check_idx  = idx_q;
    assign bus.round_pass = pass_q;
    assign bus.round_fail = fail_q;
    assign bus.fail_code  = code_q;

endmodule

// File: tb/tb_round_check_ctrl.sv
// Directed bench for round_check_ctrl with a short timeout so timeout timing is observable.
module tb_round_check_ctrl;

    localparam int MAX_LEN = 33;
    localparam int TMO     = 10;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    round_check_ctrl_if #(.MAX_LEN(MAX_LEN)) bus ();

    round_check_ctrl #(
        .MAX_LEN(MAX_LEN),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_round(input int len);
        bus.round_len = 6'(len);
        bus.start     = 1'b1;
        tick();
        bus.start     = 1'b0;
    endtask

    task automatic press_release(input int colour);
        bus.player_input = 4'(1 << colour);
        tick();
        bus.player_input = 4'd0;
        tick();
    endtask

    task automatic check_idle_result(input string tag, input int pass_exp, input int fail_exp);
        check({tag, "_pulse_pass"}, int'(bus.round_pass), pass_exp);
        check({tag, "_pulse_fail"}, int'(bus.round_fail), fail_exp);
    endtask

    initial begin
        checks           = 0;
        errors           = 0;
        reset            = 1'b1;
        bus.start        = 1'b0;
        bus.round_len    = 6'd0;
        bus.player_input = 4'd0;
        for (int i = 0; i < MAX_LEN; i++) bus.segment[i] = 2'(i % 4);

        tick();
        tick();
        check("rst_busy", int'(bus.busy), 0);
        check("rst_idx", int'(bus.check_idx), 0);
        check("rst_code", int'(bus.fail_code), 0);
        check_idle_result("rst", 0, 0);
        @(negedge clk);
        reset = 1'b0;
        tick();

        // Full pass, len 4, with a mid-round start and a long hold with extra buttons.
        start_round(4);
        check("p4_busy", int'(bus.busy), 1);
        check("p4_idx0", int'(bus.check_idx), 0);
        press_release(0);
        check("p4_idx1", int'(bus.check_idx), 1);
        bus.round_len = 6'd0;
        bus.start     = 1'b1;
        tick();
        bus.start     = 1'b0;
        check("p4_ign_start_fail", int'(bus.round_fail), 0);
        check("p4_ign_start_idx", int'(bus.check_idx), 1);
        press_release(1);
        check("p4_idx2", int'(bus.check_idx), 2);
        bus.player_input = 4'b0100;
        tick();
        bus.player_input = 4'b0110;
        for (int i = 0; i < 48; i++) tick();
        bus.player_input = 4'b0100;
        tick();
        check("p4_hold_busy", int'(bus.busy), 1);
        check("p4_hold_fail", int'(bus.round_fail), 0);
        check("p4_hold_idx", int'(bus.check_idx), 2);
        bus.player_input = 4'd0;
        tick();
        check("p4_idx3", int'(bus.check_idx), 3);
        press_release(3);
        check_idle_result("p4_pre", 0, 0);
        check("p4_pre_busy", int'(bus.busy), 1);
        tick();
        check_idle_result("p4_res", 1, 0);
        check("p4_res_busy", int'(bus.busy), 1);
        check("p4_res_idx", int'(bus.check_idx), 3);
        tick();
        check_idle_result("p4_post", 0, 0);
        check("p4_post_busy", int'(bus.busy), 0);

        // Wrong colour on the second entry.
        start_round(3);
        press_release(0);
        bus.player_input = 4'b1000;
        tick();
        bus.player_input = 4'd0;
        check_idle_result("wc_pre", 0, 0);
        tick();
        check_idle_result("wc_res", 0, 1);
        check("wc_code", int'(bus.fail_code), 0);
        check("wc_idx", int'(bus.check_idx), 1);
        tick();
        check("wc_busy", int'(bus.busy), 0);

        // Multiple buttons on the first entry; code then held while idle.
        start_round(2);
        bus.player_input = 4'b0011;
        tick();
        bus.player_input = 4'd0;
        tick();
        check_idle_result("mb_res", 0, 1);
        check("mb_code", int'(bus.fail_code), 2);
        tick();
        tick();
        tick();
        check("mb_code_held", int'(bus.fail_code), 2);
        check_idle_result("mb_idle", 0, 0);

        // Timeout: entered WAIT_PRESS at the start edge, pulse 11 edges later.
        start_round(1);
        check("to_code_clr", int'(bus.fail_code), 0);
        for (int i = 0; i < TMO; i++) begin
            tick();
            check($sformatf("to_wait%0d", i), int'(bus.round_fail), 0);
        end
        tick();
        check_idle_result("to_res", 0, 1);
        check("to_code", int'(bus.fail_code), 1);
        tick();

        // Illegal lengths.
        start_round(0);
        check("l0_pre", int'(bus.round_fail), 0);
        tick();
        check_idle_result("l0_res", 0, 1);
        check("l0_code", int'(bus.fail_code), 3);
        tick();
        start_round(34);
        tick();
        check_idle_result("l34_res", 0, 1);
        check("l34_code", int'(bus.fail_code), 3);
        tick();

        // Maximum length, all correct.
        start_round(33);
        for (int i = 0; i < MAX_LEN; i++) press_release(i % 4);
        check("max_idx", int'(bus.check_idx), 32);
        tick();
        check_idle_result("max_res", 1, 0);
        tick();
        check("max_busy", int'(bus.busy), 0);

        // Reset asserted mid-cycle in WAIT_RELEASE at index 2.
        start_round(4);
        press_release(0);
        press_release(1);
        bus.player_input = 4'b0100;
        tick();
        check("rm_idx_before", int'(bus.check_idx), 2);
        #2;
        reset = 1'b1;
        #1;
        check("rm_async_busy", int'(bus.busy), 0);
        check("rm_async_idx", int'(bus.check_idx), 0);
        bus.player_input = 4'd0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_idle_result($sformatf("rm_quiet%0d", i), 0, 0);
        end
        start_round(2);
        check("rm_new_idx0", int'(bus.check_idx), 0);
        check("rm_new_busy", int'(bus.busy), 1);
        press_release(0);
        check("rm_new_idx1", int'(bus.check_idx), 1);
        press_release(1);
        tick();
        check_idle_result("rm_new_res", 1, 0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
